// File: rtl/int_ctrl_pkg.sv
// Shared constants for the external interrupt controller: register offsets
// within the 16-byte window, default window base and CP0 HWInt width.
package int_ctrl_pkg;

    // Register offsets, indexed by addr[3:2]
    localparam logic [1:0] OFF_PEND = 2'd0;
    localparam logic [1:0] OFF_MASK = 2'd1;
    localparam logic [1:0] OFF_MODE = 2'd2;
    localparam logic [1:0] OFF_RAW  = 2'd3;

    // Default window base; must stay 16-byte aligned
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_7F20;

    // Width of the CP0 HWInt field
    localparam int unsigned HWINT_W = 6;

    // True when addr falls inside the 16-byte window starting at base
    function automatic logic window_hit(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:4] == base[31:4];
    endfunction

endpackage

// File: rtl/int_sync_edge.sv
// Per-bit two-flop synchronizer followed by a "previous" flop, producing the
// synchronized level and a one-cycle rising-edge strobe for each source.
module int_sync_edge
    import int_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;
    logic [WIDTH-1:0] prev_q;

    // Synchronizer chain plus previous-value flop; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            stage1_q <= '0;
            stage2_q <= '0;
            prev_q   <= '0;
        end else begin
            stage1_q <= async_in;
            stage2_q <= stage1_q;
            prev_q   <= stage2_q;
        end
    end

    // Level and edge views of the synchronized sources
    always_comb begin
        sync = stage2_q;
        rise = stage2_q & ~prev_q;
    end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped external interrupt controller. Synchronizes raw sources,
// captures edges or levels per source into PEND, masks them onto HWInt and
// exposes PEND/MASK/MODE/RAW on the CPU data bus. N_SRC must be 1..6.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC     = 6,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   src_in,
    input  logic [31:0]        addr,
    input  logic [3:0]         byteen,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic [HWINT_W-1:0] hwint
);

    logic [N_SRC-1:0] sync;
    logic [N_SRC-1:0] rise;

    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;

    logic             win_hit;
    logic [1:0]       off;
    logic             wr_en;
    logic [N_SRC-1:0] wr_bits;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] to_edge;

    // Bus bits that carry no meaning for this block
    logic unused_bits;
    assign unused_bits = ^{wdata[31:N_SRC], byteen[3:1], addr[1:0]};

    int_sync_edge #(
        .WIDTH (N_SRC)
    ) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .async_in (src_in),
        .sync     (sync),
        .rise     (rise)
    );

    // Bus decode: window hit, register select, write qualification
    always_comb begin
        win_hit = window_hit(addr, BASE_ADDR);
        off     = addr[3:2];
        wr_en   = win_hit & byteen[0];
        wr_bits = wdata[N_SRC-1:0];
    end

    // Register next-state: W1C/set for PEND, plain RW for MASK and MODE
    always_comb begin
        mask_d  = mask_q;
        mode_d  = mode_q;
        clr     = '0;
        to_edge = '0;
        if (wr_en) begin
            unique case (off)
                OFF_PEND: clr = wr_bits;
                OFF_MASK: mask_d = wr_bits;
                OFF_MODE: begin
                    mode_d  = wr_bits;
                    // Bits moving from level to edge start from a clean slate
                    to_edge = wr_bits & ~mode_q;
                end
                OFF_RAW:  ;
                default:  ;
            endcase
        end
        // Edge bits: a rise beats a same-cycle clear. Level bits track sync.
        pend_d = ((mode_q & (rise | (pend_q & ~clr))) | (~mode_q & sync)) & ~to_edge;
    end

    // Register file state; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_q <= '0;
            mask_q <= '1;
            mode_q <= '1;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
        end
    end

    // Read mux and masked interrupt outputs, bits above N_SRC held at 0
    always_comb begin
        rdata = '0;
        if (win_hit) begin
            unique case (off)
                OFF_PEND: rdata[N_SRC-1:0] = pend_q;
                OFF_MASK: rdata[N_SRC-1:0] = mask_q;
                OFF_MODE: rdata[N_SRC-1:0] = mode_q;
                OFF_RAW:  rdata[N_SRC-1:0] = sync;
                default:  rdata = '0;
            endcase
        end
        hwint = '0;
        hwint[N_SRC-1:0] = pend_q & mask_q;
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: table of bus vectors, directed multi-cycle
// sequences, then randomized traffic against a history-based reference model.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  src_in;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [5:0]  hwint;

    int n_chk  = 0;
    int n_pass = 0;

    int_ctrl #(
        .N_SRC     (6),
        .BASE_ADDR (32'h0000_7F20)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .src_in (src_in),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .hwint  (hwint)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        addr   = 32'h0;
        byteen = 4'h0;
        wdata  = 32'h0;
    endtask

    task automatic rd(input logic [1:0] off, input string name, input logic [31:0] exp);
        addr   = 32'h7F20 | {28'h0, off, 2'b00};
        byteen = 4'h0;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic hw(input string name, input logic [5:0] exp);
        check(name, {26'h0, hwint}, {26'h0, exp});
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        addr   = 32'h7F20 | {28'h0, off, 2'b00};
        byteen = 4'h1;
        wdata  = data;
        tick();
        idle();
    endtask

    // ---------------- reference model ----------------
    logic [5:0] m_pend, m_mask, m_mode;
    logic [5:0] hist[$];  // src value presented before each of the last 3 edges

    task automatic m_reset();
        m_pend = '0;
        m_mask = 6'h3F;
        m_mode = 6'h3F;
        hist   = {6'h0, 6'h0, 6'h0};
    endtask

    // Synchronized level seen now is the source as presented two edges ago
    function automatic logic [31:0] m_read(input logic [1:0] off);
        case (off)
            2'd0:    return {26'h0, m_pend};
            2'd1:    return {26'h0, m_mask};
            2'd2:    return {26'h0, m_mode};
            default: return {26'h0, hist[1]};
        endcase
    endfunction

    task automatic m_edge(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                          input logic [5:0] src);
        logic       we;
        logic [5:0] s, p, nxt;
        we = (a[31:4] == 28'h00007F2) && be[0];
        s  = hist[1];
        p  = hist[0];
        for (int i = 0; i < 6; i++) begin
            if (m_mode[i]) begin
                if (s[i] && !p[i]) nxt[i] = 1'b1;
                else if (we && a[3:2] == 2'd0 && d[i]) nxt[i] = 1'b0;
                else nxt[i] = m_pend[i];
            end else begin
                nxt[i] = s[i];
            end
            if (we && a[3:2] == 2'd2 && d[i] && !m_mode[i]) nxt[i] = 1'b0;
        end
        m_pend = nxt;
        if (we && a[3:2] == 2'd1) m_mask = d[5:0];
        if (we && a[3:2] == 2'd2) m_mode = d[5:0];
        hist.push_back(src);
        void'(hist.pop_front());
    endtask

    // ---------------- bus vector table ----------------
    typedef struct {
        string       name;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] exp_rdata;
        logic [5:0]  exp_hwint;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{"rst_pend",     32'h7F20, 4'h0, 32'h0,        32'h00, 6'h0};
        vecs[1]  = '{"rst_mask",     32'h7F24, 4'h0, 32'h0,        32'h3F, 6'h0};
        vecs[2]  = '{"rst_mode",     32'h7F28, 4'h0, 32'h0,        32'h3F, 6'h0};
        vecs[3]  = '{"rst_raw",      32'h7F2C, 4'h0, 32'h0,        32'h00, 6'h0};
        vecs[4]  = '{"miss_read",    32'h7F30, 4'h0, 32'h0,        32'h00, 6'h0};
        vecs[5]  = '{"wr_mask_old",  32'h7F24, 4'h1, 32'h3B,       32'h3F, 6'h0};
        vecs[6]  = '{"mask_3b",      32'h7F24, 4'h0, 32'h0,        32'h3B, 6'h0};
        vecs[7]  = '{"be1_ignored",  32'h7F24, 4'h2, 32'h0,        32'h3B, 6'h0};
        vecs[8]  = '{"mask_kept",    32'h7F24, 4'h0, 32'h0,        32'h3B, 6'h0};
        vecs[9]  = '{"wr_mask_hi",   32'h7F27, 4'h1, 32'hFFFF_FF3F, 32'h3B, 6'h0};
        vecs[10] = '{"mask_3f",      32'h7F24, 4'h0, 32'h0,        32'h3F, 6'h0};
        vecs[11] = '{"wr_raw",       32'h7F2C, 4'hF, 32'h3F,       32'h00, 6'h0};
        vecs[12] = '{"miss_wr_mask", 32'h7F34, 4'h1, 32'h00,       32'h00, 6'h0};
        vecs[13] = '{"mask_intact",  32'h7F24, 4'h0, 32'h0,        32'h3F, 6'h0};

        reset  = 1'b0;
        src_in = 6'h0;
        idle();
        tick();
        tick();
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            addr   = vecs[i].a;
            byteen = vecs[i].be;
            wdata  = vecs[i].d;
            #1;
            check(vecs[i].name, rdata, vecs[i].exp_rdata);
            hw({vecs[i].name, "_hw"}, vecs[i].exp_hwint);
            tick();
        end
        idle();

        // Edge latency and acknowledge
        src_in[2] = 1'b1;
        tick();
        hw("lat_e0", 6'h00);
        tick();
        hw("lat_e1", 6'h00);
        rd(OFF_RAW, "lat_raw", 32'h04);
        tick();
        hw("lat_e2", 6'h04);
        rd(OFF_PEND, "lat_pend", 32'h04);
        addr   = 32'h7F20;
        byteen = 4'h1;
        wdata  = 32'h04;
        #1;
        hw("ack_cycle", 6'h04);
        tick();
        idle();
        hw("ack_next", 6'h00);
        repeat (4) tick();
        hw("held_no_reset", 6'h00);
        rd(OFF_PEND, "held_pend", 32'h00);
        src_in[2] = 1'b0;
        repeat (3) tick();

        // Mask hides hwint but not PEND
        wr(OFF_MASK, 32'h3B);
        src_in[2] = 1'b1;
        repeat (3) tick();
        rd(OFF_PEND, "masked_pend", 32'h04);
        hw("masked_hw", 6'h00);
        wr(OFF_MASK, 32'h3F);
        hw("unmasked_hw", 6'h04);
        src_in[2] = 1'b0;
        wr(OFF_PEND, 32'h04);
        repeat (3) tick();

        // Level mode
        wr(OFF_MODE, 32'h3E);
        src_in[0] = 1'b1;
        repeat (3) tick();
        rd(OFF_PEND, "level_pend", 32'h01);
        wr(OFF_PEND, 32'h01);
        rd(OFF_PEND, "level_w1c", 32'h01);
        src_in[0] = 1'b0;
        tick();
        tick();
        rd(OFF_PEND, "level_lag", 32'h01);
        tick();
        rd(OFF_PEND, "level_drop", 32'h00);
        src_in[0] = 1'b1;
        repeat (3) tick();
        rd(OFF_PEND, "level_pend2", 32'h01);
        wr(OFF_MODE, 32'h3F);
        rd(OFF_PEND, "mode_to_edge", 32'h00);
        tick();
        tick();
        rd(OFF_PEND, "edge_no_rise", 32'h00);
        src_in[0] = 1'b0;
        repeat (3) tick();

        // Rise and W1C in the same cycle on an already-pending bit
        src_in[1] = 1'b1;
        repeat (3) tick();
        src_in[1] = 1'b0;
        repeat (3) tick();
        rd(OFF_PEND, "sticky_pend", 32'h02);
        src_in[1] = 1'b1;
        tick();
        tick();
        wr(OFF_PEND, 32'h02);
        rd(OFF_PEND, "set_beats_clr", 32'h02);
        wr(OFF_PEND, 32'h02);
        rd(OFF_PEND, "clr_after", 32'h00);
        src_in[1] = 1'b0;
        repeat (3) tick();

        // Reset mid-operation
        src_in = 6'h05;
        repeat (3) tick();
        src_in = 6'h00;
        rd(OFF_PEND, "pre_rst_pend", 32'h05);
        src_in[3] = 1'b1;
        tick();
        reset  = 1'b0;
        addr   = 32'h7F24;
        byteen = 4'h1;
        wdata  = 32'h0;
        tick();
        reset  = 1'b1;
        src_in = 6'h00;
        idle();
        rd(OFF_PEND, "mid_rst_pend", 32'h00);
        rd(OFF_MASK, "mid_rst_mask", 32'h3F);
        hw("mid_rst_hw", 6'h00);
        tick();
        rd(OFF_MODE, "mid_rst_mode", 32'h3F);
        rd(OFF_RAW, "mid_rst_raw", 32'h00);
        repeat (4) tick();
        rd(OFF_PEND, "post_rst_pend", 32'h00);
        hw("post_rst_hw", 6'h00);

        // Randomized traffic against the model
        reset = 1'b0;
        idle();
        tick();
        reset = 1'b1;
        m_reset();
        for (int c = 0; c < 500; c++) begin
            logic [31:0] a;
            int          kind;
            if ($urandom_range(3) == 0) src_in = 6'($urandom_range(63));
            kind = int'($urandom_range(3));
            if (kind == 3) begin
                a = $urandom;
                if (a[31:4] == 28'h00007F2) a[4] = ~a[4];
            end else begin
                a = 32'h7F20 | ($urandom & 32'hF);
            end
            addr   = a;
            byteen = (kind == 0) ? 4'h0 : 4'($urandom_range(15));
            wdata  = $urandom;
            #1;
            check("rand_rdata", rdata,
                  (a[31:4] == 28'h00007F2) ? m_read(a[3:2]) : 32'h0);
            hw("rand_hwint", m_pend & m_mask);
            m_edge(addr, byteen, wdata, src_in);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
